// File: rtl/motor_fault_pkg.sv
// Shared definitions for the motor-fault chain: classifier fault codes and the
// alarm manager FSM state encoding.
package motor_fault_pkg;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_BEARING = 2'b01;
  localparam logic [1:0] FAULT_ROTOR   = 2'b10;
  localparam logic [1:0] FAULT_STATOR  = 2'b11;

  typedef enum logic [1:0] {
    StHealthy    = 2'd0,
    StPending    = 2'd1,
    StFaulted    = 2'd2,
    StRecovering = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/persist_counter.sv
// Saturating persistence counter with clear / load-1 / increment controls and a flag
// that is high when the next increment would reach the selected threshold.
module persist_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  input  logic [W-1:0] thresh,
  output logic         at_last
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load1) begin
      count_d = W'(1);
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Thresholds are always >= 2, so thresh - 1 never underflows.
  assign at_last = (count_q == (thresh - W'(1)));

endmodule

// File: rtl/fault_alarm_manager.sv
// Debounces raw classifier fault codes into a confirmed fault state, raises a sticky
// acknowledged alarm, tracks peak RMS while faulted and counts confirmed fault events.
module fault_alarm_manager
  import motor_fault_pkg::*;
#(
  parameter int unsigned CONFIRM_CNT = 16,
  parameter int unsigned CLEAR_CNT   = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       fault_in,
  input  logic [31:0]      rms_in,
  input  logic             ack,
  output logic [1:0]       fault_state,
  output logic             alarm,
  output logic [1:0]       alarm_code,
  output logic [31:0]      peak_rms,
  output logic [CNT_W-1:0] event_count,
  output logic [1:0]       fsm_state
);

  localparam int unsigned MaxCnt = (CONFIRM_CNT > CLEAR_CNT) ? CONFIRM_CNT : CLEAR_CNT;
  localparam int unsigned CW     = $clog2(MaxCnt) + 1;

  fsm_state_e       state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       fs_q, fs_d;
  logic             alarm_q, alarm_d;
  logic [1:0]       code_q, code_d;
  logic [31:0]      peak_q, peak_d;
  logic [CNT_W-1:0] ev_q, ev_d;
  logic             clr, load1, inc, at_last;
  logic [CW-1:0]    thresh;

  // One counter serves both debounce directions; only RECOVERING counts toward clear.
  assign thresh = (state_q == StRecovering) ? CW'(CLEAR_CNT) : CW'(CONFIRM_CNT);

  persist_counter #(
    .W (CW)
  ) u_persist_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .load1   (load1),
    .inc     (inc),
    .thresh  (thresh),
    .at_last (at_last)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    fs_d    = fs_q;
    alarm_d = alarm_q;
    code_d  = code_q;
    peak_d  = peak_q;
    ev_d    = ev_q;
    clr     = 1'b0;
    load1   = 1'b0;
    inc     = 1'b0;

    if (ack && alarm_q) begin
      alarm_d = 1'b0;
    end

    case (state_q)
      StHealthy: begin
        if (fault_in != FAULT_NONE) begin
          state_d = StPending;
          cand_d  = fault_in;
          load1   = 1'b1;
        end
      end
      StPending: begin
        if (fault_in == FAULT_NONE) begin
          state_d = StHealthy;
          clr     = 1'b1;
        end else if (fault_in == cand_q) begin
          if (at_last) begin
            // Confirmation overrides a same-edge acknowledge.
            state_d = StFaulted;
            fs_d    = cand_q;
            alarm_d = 1'b1;
            code_d  = cand_q;
            peak_d  = rms_in;
            clr     = 1'b1;
            if (ev_q != '1) begin
              ev_d = ev_q + CNT_W'(1);
            end
          end else begin
            inc = 1'b1;
          end
        end else begin
          cand_d = fault_in;
          load1  = 1'b1;
        end
      end
      StFaulted: begin
        if (rms_in > peak_q) begin
          peak_d = rms_in;
        end
        if (fault_in == FAULT_NONE) begin
          state_d = StRecovering;
          load1   = 1'b1;
        end
      end
      StRecovering: begin
        if ((fault_in == FAULT_NONE) && at_last) begin
          state_d = StHealthy;
          fs_d    = FAULT_NONE;
          clr     = 1'b1;
        end else begin
          if (rms_in > peak_q) begin
            peak_d = rms_in;
          end
          if (fault_in == FAULT_NONE) begin
            inc = 1'b1;
          end else begin
            state_d = StFaulted;
            clr     = 1'b1;
          end
        end
      end
      default: begin
        state_d = StHealthy;
        clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHealthy;
      cand_q  <= FAULT_NONE;
      fs_q    <= FAULT_NONE;
      alarm_q <= 1'b0;
      code_q  <= FAULT_NONE;
      peak_q  <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      fs_q    <= fs_d;
      alarm_q <= alarm_d;
      code_q  <= code_d;
      peak_q  <= peak_d;
      ev_q    <= ev_d;
    end
  end

  assign fault_state = fs_q;
  assign alarm       = alarm_q;
  assign alarm_code  = code_q;
  assign peak_rms    = peak_q;
  assign event_count = ev_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fault_alarm_manager.sv
// Scoreboard bench for fault_alarm_manager: default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise event counter saturation.
module tb_fault_alarm_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fault_in;
  logic [31:0] rms_in;
  logic        ack;

  logic [1:0]  fs_a, code_a, st_a, fs_b, code_b, st_b;
  logic        alarm_a, alarm_b;
  logic [31:0] peak_a, peak_b;
  logic [7:0]  ev_a;
  logic [1:0]  ev_b;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  typedef struct {
    string       tag;
    logic [1:0]  fs;
    logic        alarm;
    logic [1:0]  code;
    logic [31:0] peak;
    logic [7:0]  ev;
    logic [1:0]  evb;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fault_alarm_manager #(
    .CONFIRM_CNT (16),
    .CLEAR_CNT   (32),
    .CNT_W       (8)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .fault_in    (fault_in),
    .rms_in      (rms_in),
    .ack         (ack),
    .fault_state (fs_a),
    .alarm       (alarm_a),
    .alarm_code  (code_a),
    .peak_rms    (peak_a),
    .event_count (ev_a),
    .fsm_state   (st_a)
  );

  fault_alarm_manager #(
    .CONFIRM_CNT (16),
    .CLEAR_CNT   (32),
    .CNT_W       (2)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .fault_in    (fault_in),
    .rms_in      (rms_in),
    .ack         (ack),
    .fault_state (fs_b),
    .alarm       (alarm_b),
    .alarm_code  (code_b),
    .peak_rms    (peak_b),
    .event_count (ev_b),
    .fsm_state   (st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [1:0] fs, input logic alarm,
                              input logic [1:0] code, input logic [31:0] peak,
                              input int unsigned ev, input logic [1:0] st);
    exp_t e;
    e.tag   = tag;
    e.fs    = fs;
    e.alarm = alarm;
    e.code  = code;
    e.peak  = peak;
    e.ev    = 8'(ev);
    e.evb   = (ev > 3) ? 2'd3 : 2'(ev);
    e.st    = st;
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".fault_state"}, 32'(fs_a), 32'(e.fs));
    check({e.tag, ".alarm"}, 32'(alarm_a), 32'(e.alarm));
    check({e.tag, ".alarm_code"}, 32'(code_a), 32'(e.code));
    check({e.tag, ".peak_rms"}, peak_a, e.peak);
    check({e.tag, ".event_count"}, 32'(ev_a), 32'(e.ev));
    check({e.tag, ".fsm_state"}, 32'(st_a), 32'(e.st));
    check({e.tag, ".b.event_count"}, 32'(ev_b), 32'(e.evb));
    check({e.tag, ".b.fsm_state"}, 32'(st_b), 32'(e.st));
  endtask

  // Drive one sample, clock it in, sample outputs 1 time unit after the edge.
  task automatic step(input logic [1:0] fi, input logic [31:0] rms, input logic a);
    fault_in = fi;
    rms_in   = rms;
    ack      = a;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input logic [1:0] fi, input logic [31:0] rms, input logic a,
                          input exp_t e);
    fault_in = fi;
    rms_in   = rms;
    ack      = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    fault_in = 2'b00;
    rms_in   = '0;
    ack      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk("reset", 2'd0, 1'b0, 2'd0, 32'd0, 0, 2'd0));
    pop_check();
    rst = 1'b0;

    // 1: async reset mid-PENDING, then a full fresh confirm is needed
    for (int i = 0; i < 9; i++) step(2'b01, 32'd5, 1'b0);
    step_chk(2'b01, 32'd5, 1'b0, mk("t1_pending10", 2'd0, 1'b0, 2'd0, 32'd0, 0, 2'd1));
    #2 rst = 1'b1;
    #1;
    sb.push_back(mk("t1_async_rst", 2'd0, 1'b0, 2'd0, 32'd0, 0, 2'd0));
    pop_check();
    #2 rst = 1'b0;
    for (int i = 0; i < 14; i++) step(2'b01, 32'd5, 1'b0);
    step_chk(2'b01, 32'd5, 1'b0, mk("t1_15th", 2'd0, 1'b0, 2'd0, 32'd0, 0, 2'd1));
    step_chk(2'b01, 32'd5, 1'b0, mk("t2_confirm", 2'd1, 1'b1, 2'd1, 32'd5, 1, 2'd2));

    // 2b: only 15 samples then a zero -> no alarm
    do_reset();
    for (int i = 0; i < 14; i++) step(2'b01, 32'd5, 1'b0);
    step_chk(2'b01, 32'd5, 1'b0, mk("t2_15only", 2'd0, 1'b0, 2'd0, 32'd0, 0, 2'd1));
    step_chk(2'b00, 32'd5, 1'b0, mk("t2_dropout", 2'd0, 1'b0, 2'd0, 32'd0, 0, 2'd0));

    // 3: candidate restart on a different code
    for (int i = 0; i < 10; i++) step(2'b10, 32'd7, 1'b0);
    for (int i = 0; i < 14; i++) step(2'b11, 32'd7, 1'b0);
    step_chk(2'b11, 32'd7, 1'b0, mk("t3_15th", 2'd0, 1'b0, 2'd0, 32'd0, 0, 2'd1));
    step_chk(2'b11, 32'd7, 1'b0, mk("t3_confirm", 2'd3, 1'b1, 2'd3, 32'd7, 1, 2'd2));

    // 4: peak tracking and interrupted recovery
    do_reset();
    for (int i = 0; i < 15; i++) step(2'b10, 32'd50, 1'b0);
    step_chk(2'b10, 32'd100, 1'b0, mk("t4_confirm", 2'd2, 1'b1, 2'd2, 32'd100, 1, 2'd2));
    step(2'b10, 32'd500, 1'b0);
    step_chk(2'b10, 32'd300, 1'b0, mk("t4_peak", 2'd2, 1'b1, 2'd2, 32'd500, 1, 2'd2));
    for (int i = 0; i < 30; i++) step(2'b00, 32'd0, 1'b0);
    step_chk(2'b00, 32'd0, 1'b0, mk("t4_31zeros", 2'd2, 1'b1, 2'd2, 32'd500, 1, 2'd3));
    step_chk(2'b01, 32'd0, 1'b0, mk("t4_refault", 2'd2, 1'b1, 2'd2, 32'd500, 1, 2'd2));
    for (int i = 0; i < 31; i++) step(2'b00, 32'd0, 1'b0);
    sb.push_back(mk("t4_31of32", 2'd2, 1'b1, 2'd2, 32'd500, 1, 2'd3));
    pop_check();
    step_chk(2'b00, 32'd0, 1'b0, mk("t4_cleared", 2'd0, 1'b1, 2'd2, 32'd500, 1, 2'd0));

    // 5: ack on the confirm edge loses, ack one cycle later clears
    do_reset();
    for (int i = 0; i < 15; i++) step(2'b01, 32'd20, 1'b0);
    step_chk(2'b01, 32'd20, 1'b1, mk("t5_ack_on_confirm", 2'd1, 1'b1, 2'd1, 32'd20, 1, 2'd2));
    step_chk(2'b01, 32'd20, 1'b1, mk("t5_ack_clears", 2'd1, 1'b0, 2'd1, 32'd20, 1, 2'd2));
    step_chk(2'b01, 32'd20, 1'b0, mk("t5_no_reraise", 2'd1, 1'b0, 2'd1, 32'd20, 1, 2'd2));

    // 6: five separate confirmations, narrow instance saturates at 3
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      for (int i = 0; i < 15; i++) step(2'b01, 32'd9, 1'b0);
      step_chk(2'b01, 32'd9, 1'b0, mk($sformatf("t6_confirm%0d", n), 2'd1, 1'b1, 2'd1,
                                       32'd9, n, 2'd2));
      for (int i = 0; i < 31; i++) step(2'b00, 32'd0, 1'b0);
      step_chk(2'b00, 32'd0, 1'b0, mk($sformatf("t6_clear%0d", n), 2'd0, 1'b1, 2'd1,
                                       32'd9, n, 2'd0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
